game_state_link: RTL and testbench



---
 rtl/game_link_pkg.sv | 45 ++++
 rtl/game_link_rx.sv | 138 +++++++++++++
 rtl/game_state_link.sv | 125 ++++++++++++
 tb/tb_game_state_link.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/game_link_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_link_pkg
// Purpose  : Shared types, constants and checksum helper for the framed
//            game-state serial link.
// Revision : 1.0 - initial release
// ============================================================================
package game_link_pkg;

    // Default frame start marker.
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Widest payload the sum8 helper accepts (bytes).
    localparam int MAX_PAYLOAD_BYTES = 64;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SYNC = 2'd1,
        TX_DATA = 2'd2,
        TX_SUM  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_HUNT = 2'd0,
        RX_DATA = 2'd1,
        RX_SUM  = 2'd2
    } rx_state_t;

    // Mod-256 sum of the low nbytes bytes of a (zero-extended) payload word.
    function automatic logic [7:0] sum8(
        input logic [8*MAX_PAYLOAD_BYTES-1:0] word,
        input int                             nbytes
    );
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < MAX_PAYLOAD_BYTES; i++) begin
            if (i < nbytes) begin
                acc = acc + word[8*i +: 8];
            end
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_link_rx.sv
`default_nettype none
// ============================================================================
// Module   : game_link_rx
// Purpose  : Receive side of the game-state link: hunts for SYNC, collects
//            the payload, validates the checksum, tracks link timeout and
//            counts bad or aborted frames.
// Revision : 1.0 - initial release
// ============================================================================
module game_link_rx
    import game_link_pkg::*;
#(
    parameter int         PAYLOAD_BYTES = 4,
    parameter logic [7:0] SYNC_BYTE     = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_TICKS = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       timing_tick_i,
    input  logic [7:0]                 rx_byte_i,
    input  logic                       rx_valid_i,
    output logic [8*PAYLOAD_BYTES-1:0] rx_payload_o,
    output logic                       rx_frame_ok_o,
    output logic                       link_up_o,
    output logic [7:0]                 err_count_o
);

    localparam int W     = 8 * PAYLOAD_BYTES;
    localparam int IDX_W = $clog2(PAYLOAD_BYTES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_TICKS);

    rx_state_t         state_q;
    logic [W-1:0]      shift_q;
    logic [W-1:0]      payload_q;
    logic [7:0]        sum_q;
    logic [IDX_W-1:0]  idx_q;
    logic              tick_seen_q;
    logic              frame_ok_q;
    logic              link_up_q;
    logic [7:0]        err_q;
    logic [TO_W-1:0]   to_q;
    logic [TO_W-1:0]   to_d;

    logic abort_d;
    logic good_d;
    logic bad_d;

    // A frame may straddle one tick boundary; the second tick after SYNC aborts it.
    assign abort_d = (state_q != RX_HUNT) && timing_tick_i && tick_seen_q;
    assign good_d  = (state_q == RX_SUM) && rx_valid_i && !abort_d
                     && (rx_byte_i == sum_q);
    assign bad_d   = (state_q == RX_SUM) && rx_valid_i && !abort_d
                     && (rx_byte_i != sum_q);

    // Timeout counter next value: a good frame clears it even on a tick cycle.
    always_comb begin
        to_d = to_q;
        if (good_d) begin
            to_d = '0;
        end else if (timing_tick_i && (to_q != TO_MAX)) begin
            to_d = to_q + TO_W'(1);
        end
    end

    // Frame hunt/collect/check FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RX_HUNT;
            shift_q     <= '0;
            payload_q   <= '0;
            sum_q       <= 8'h00;
            idx_q       <= '0;
            tick_seen_q <= 1'b0;
            frame_ok_q  <= 1'b0;
            link_up_q   <= 1'b0;
            err_q       <= 8'h00;
            to_q        <= '0;
        end else begin
            frame_ok_q <= good_d;
            to_q       <= to_d;
            link_up_q  <= good_d | (link_up_q & (to_d != TO_MAX));

            if ((bad_d || abort_d) && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end

            if (abort_d) begin
                state_q <= RX_HUNT;
            end else begin
                case (state_q)
                    RX_HUNT: begin
                        if (rx_valid_i && (rx_byte_i == SYNC_BYTE)) begin
                            state_q     <= RX_DATA;
                            idx_q       <= '0;
                            sum_q       <= 8'h00;
                            tick_seen_q <= 1'b0;
                        end
                    end
                    RX_DATA: begin
                        if (timing_tick_i) begin
                            tick_seen_q <= 1'b1;
                        end
                        if (rx_valid_i) begin
                            shift_q <= (shift_q << 8) | W'(rx_byte_i);
                            sum_q   <= sum_q + rx_byte_i;
                            if (idx_q == LAST_IDX) begin
                                state_q <= RX_SUM;
                            end else begin
                                idx_q <= idx_q + IDX_W'(1);
                            end
                        end
                    end
                    RX_SUM: begin
                        if (timing_tick_i) begin
                            tick_seen_q <= 1'b1;
                        end
                        if (rx_valid_i) begin
                            state_q <= RX_HUNT;
                            if (good_d) begin
                                payload_q <= shift_q;
                            end
                        end
                    end
                    default: state_q <= RX_HUNT;
                endcase
            end
        end
    end

    assign rx_payload_o  = payload_q;
    assign rx_frame_ok_o = frame_ok_q;
    assign link_up_o     = link_up_q;
    assign err_count_o   = err_q;

endmodule
`default_nettype wire

// File: rtl/game_state_link.sv
`default_nettype none
// ============================================================================
// Module   : game_state_link
// Purpose  : Framed, checksummed game-state link between two boards. The TX
//            FSM serialises a payload word per timing tick into
//            SYNC / payload (MSB first) / checksum bytes; the RX path lives
//            in game_link_rx.
// Revision : 1.0 - initial release
// ============================================================================
module game_state_link
    import game_link_pkg::*;
#(
    parameter int         PAYLOAD_BYTES = 4,
    parameter logic [7:0] SYNC_BYTE     = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_TICKS = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       timing_tick_i,
    input  logic [8*PAYLOAD_BYTES-1:0] tx_payload_i,
    output logic [7:0]                 tx_byte_o,
    output logic                       tx_valid_o,
    input  logic                       tx_ready_i,
    input  logic [7:0]                 rx_byte_i,
    input  logic                       rx_valid_i,
    output logic [8*PAYLOAD_BYTES-1:0] rx_payload_o,
    output logic                       rx_frame_ok_o,
    output logic                       link_up_o,
    output logic [7:0]                 err_count_o
);

    localparam int W     = 8 * PAYLOAD_BYTES;
    localparam int IDX_W = $clog2(PAYLOAD_BYTES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

    tx_state_t        state_q;
    logic [W-1:0]     shadow_q;
    logic [7:0]       sum_q;
    logic [7:0]       sum_d;
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       tx_byte_q;
    logic             tx_valid_q;

    // Running checksum including the data byte being transferred this cycle.
    assign sum_d = sum_q + tx_byte_q;

    // TX frame FSM. The shadow word is shifted left as bytes go out so the
    // next byte is always in its top lane; ticks outside TX_IDLE are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= TX_IDLE;
            shadow_q   <= '0;
            sum_q      <= 8'h00;
            idx_q      <= '0;
            tx_byte_q  <= 8'h00;
            tx_valid_q <= 1'b0;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    if (timing_tick_i) begin
                        shadow_q   <= tx_payload_i;
                        sum_q      <= 8'h00;
                        idx_q      <= '0;
                        tx_byte_q  <= SYNC_BYTE;
                        tx_valid_q <= 1'b1;
                        state_q    <= TX_SYNC;
                    end
                end
                TX_SYNC: begin
                    if (tx_ready_i) begin
                        tx_byte_q <= shadow_q[W-1 -: 8];
                        shadow_q  <= shadow_q << 8;
                        state_q   <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_ready_i) begin
                        sum_q <= sum_d;
                        if (idx_q == LAST_IDX) begin
                            tx_byte_q <= sum_d;
                            state_q   <= TX_SUM;
                        end else begin
                            idx_q     <= idx_q + IDX_W'(1);
                            tx_byte_q <= shadow_q[W-1 -: 8];
                            shadow_q  <= shadow_q << 8;
                        end
                    end
                end
                TX_SUM: begin
                    if (tx_ready_i) begin
                        tx_byte_q  <= 8'h00;
                        tx_valid_q <= 1'b0;
                        state_q    <= TX_IDLE;
                    end
                end
                default: begin
                    tx_valid_q <= 1'b0;
                    state_q    <= TX_IDLE;
                end
            endcase
        end
    end

    assign tx_byte_o  = tx_byte_q;
    assign tx_valid_o = tx_valid_q;

    game_link_rx #(
        .PAYLOAD_BYTES (PAYLOAD_BYTES),
        .SYNC_BYTE     (SYNC_BYTE),
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_rx (
        .clk           (clk),
        .rst           (rst),
        .timing_tick_i (timing_tick_i),
        .rx_byte_i     (rx_byte_i),
        .rx_valid_i    (rx_valid_i),
        .rx_payload_o  (rx_payload_o),
        .rx_frame_ok_o (rx_frame_ok_o),
        .link_up_o     (link_up_o),
        .err_count_o   (err_count_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_game_state_link.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_state_link
// Purpose  : Directed self-checking bench for game_state_link
//            (PAYLOAD_BYTES=4, SYNC=A5, TIMEOUT_TICKS=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_state_link;

    logic        clk = 1'b0;
    logic        rst;
    logic        timing_tick;
    logic [31:0] tx_payload;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [31:0] rx_payload;
    logic        rx_frame_ok;
    logic        link_up;
    logic [7:0]  err_count;

    int vectors    = 0;
    int miscompares = 0;
    int ok_pulses  = 0;
    logic [7:0] txq[$];
    logic [7:0] held;

    always #5 clk = ~clk;

    game_state_link #(
        .PAYLOAD_BYTES (4),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_TICKS (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .timing_tick_i (timing_tick),
        .tx_payload_i  (tx_payload),
        .tx_byte_o     (tx_byte),
        .tx_valid_o    (tx_valid),
        .tx_ready_i    (tx_ready),
        .rx_byte_i     (rx_byte),
        .rx_valid_i    (rx_valid),
        .rx_payload_o  (rx_payload),
        .rx_frame_ok_o (rx_frame_ok),
        .link_up_o     (link_up),
        .err_count_o   (err_count)
    );

    // Observe handshakes and frame_ok pulses mid-cycle, after inputs settle.
    always @(negedge clk) begin
        #1;
        if (tx_valid && tx_ready) txq.push_back(tx_byte);
        if (rx_frame_ok) ok_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick_pulse();
        @(negedge clk) timing_tick = 1'b1;
        @(negedge clk) timing_tick = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic chk_txq(input string tag, input logic [47:0] exp);
        chk({tag, "_len"}, 32'(txq.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s_b%0d", tag, i),
                (i < txq.size()) ? 32'(txq[i]) : 32'hxxxx_xxxx,
                32'(exp[8*(5-i) +: 8]));
        end
    endtask

    initial begin
        int pulses_before;
        rst         = 1'b1;
        timing_tick = 1'b0;
        tx_payload  = 32'h0;
        tx_ready    = 1'b0;
        rx_byte     = 8'h00;
        rx_valid    = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_byte", 32'(tx_byte), 32'h00);
        chk("rst_rx_payload", rx_payload, 32'h0);
        chk("rst_frame_ok", 32'(rx_frame_ok), 32'd0);
        chk("rst_link_up", 32'(link_up), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        rst = 1'b0;

        // Send 12345678: valid rises the cycle after the tick with SYNC
        tx_payload = 32'h12345678;
        tx_ready   = 1'b1;
        tick_pulse();
        chk("tx_valid_rise", 32'(tx_valid), 32'd1);
        chk("tx_first_byte", 32'(tx_byte), 32'hA5);
        repeat (10) @(negedge clk);
        chk_txq("tx_frame", 48'hA5_12_34_56_78_14);
        chk("tx_idle_after", 32'(tx_valid), 32'd0);

        // Good frame
        pulses_before = ok_pulses;
        send(8'hA5); send(8'h12); send(8'h34); send(8'h56); send(8'h78); send(8'h14);
        chk("good_frame_ok_now", 32'(rx_frame_ok), 32'd1);
        chk("good_payload", rx_payload, 32'h12345678);
        chk("good_link_up", 32'(link_up), 32'd1);
        @(negedge clk);
        chk("good_frame_ok_drop", 32'(rx_frame_ok), 32'd0);
        chk("good_one_pulse", 32'(ok_pulses - pulses_before), 32'd1);

        // Bad checksum
        pulses_before = ok_pulses;
        send(8'hA5); send(8'h12); send(8'h34); send(8'h56); send(8'h78); send(8'h15);
        chk("bad_err_now", 32'(err_count), 32'd1);
        @(negedge clk);
        chk("bad_payload_kept", rx_payload, 32'h12345678);
        chk("bad_no_pulse", 32'(ok_pulses - pulses_before), 32'd0);

        // Garbage then frame with SYNC value inside the payload
        pulses_before = ok_pulses;
        send(8'h00); send(8'hFF); send(8'hA5); send(8'hA5);
        send(8'h00); send(8'h00); send(8'h01); send(8'hA6);
        @(negedge clk);
        chk("resync_payload", rx_payload, 32'hA5000001);
        chk("resync_pulse", 32'(ok_pulses - pulses_before), 32'd1);
        chk("resync_err", 32'(err_count), 32'd1);

        // Timeout: link holds through 7 ticks, drops right after the 8th
        for (int k = 0; k < 7; k++) tick_pulse();
        chk("timeout_7_link", 32'(link_up), 32'd1);
        tick_pulse();
        chk("timeout_8_link", 32'(link_up), 32'd0);
        send(8'hA5); send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h0A);
        chk("relink_link_up", 32'(link_up), 32'd1);
        chk("relink_payload", rx_payload, 32'h01020304);

        // Abort: second tick while a frame is being collected
        send(8'hA5); send(8'h01);
        tick_pulse();
        send(8'h02);
        chk("abort_err_before", 32'(err_count), 32'd1);
        tick_pulse();
        chk("abort_err", 32'(err_count), 32'd2);
        send(8'h03); send(8'h04); send(8'h0A);
        @(negedge clk);
        chk("abort_tail_err", 32'(err_count), 32'd2);
        chk("abort_payload_kept", rx_payload, 32'h01020304);

        // Backpressure with an extra tick mid-frame
        repeat (10) @(negedge clk);
        txq.delete();
        tx_payload = 32'hDEADBEEF;
        tick_pulse();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 5) chk("bp_hold_stable", 32'(tx_byte), 32'(held));
            tx_ready = i[0];
            if (i == 3) begin
                timing_tick = 1'b1;
                tx_payload  = 32'h11111111;
            end else begin
                timing_tick = 1'b0;
            end
            if (i == 4) held = tx_byte;
        end
        @(negedge clk);
        timing_tick = 1'b0;
        tx_ready    = 1'b1;
        repeat (10) @(negedge clk);
        chk_txq("bp_frame", 48'hA5_DE_AD_BE_EF_38);
        chk("bp_no_second", 32'(tx_valid), 32'd0);

        // Reset mid-RX frame
        send(8'hA5); send(8'h11); send(8'h22);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("midrst_err", 32'(err_count), 32'd0);
        chk("midrst_payload", rx_payload, 32'h0);
        chk("midrst_link", 32'(link_up), 32'd0);
        pulses_before = ok_pulses;
        send(8'h33); send(8'h44); send(8'hAA);
        @(negedge clk);
        chk("midrst_tail_err", 32'(err_count), 32'd0);
        chk("midrst_no_pulse", 32'(ok_pulses - pulses_before), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
